// File: rtl/fc2_lii_packer.sv
// fc2_lii_packer: buffers the activation, weight and bias byte streams in
// separate lane FIFOs and joins one byte from each into a single PW-bit LII
// beat for the fc2 stage's p0 input channel.

// Single-lane circular FIFO, DEPTH x 8 bits, with an explicit occupancy count.
module fc2_lii_lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       aclk,
  input  logic       arstn,
  input  logic [7:0] push_data,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;

  // Ready comes only from the registered count, so a full lane stays
  // not-ready even in a cycle where the join pops it.
  assign push_ready = (count != CW'(DEPTH));
  assign push       = push_valid & push_ready;
  assign pop_data   = mem[rd_ptr];
  assign not_empty  = (count != '0);

  // Storage write; the pointers and count fully define what is valid.
  // NOTE: the data array is deliberately left out of reset -- stale contents
  // are never observable because reads are gated by the occupancy count.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Top level: three lane FIFOs feeding a single registered output beat.
module fc2_lii_packer #(
  parameter int       PW     = 64,
  parameter int       DEPTH  = 4,
  parameter bit [7:0] SRC_ID = 8'h00,
  parameter bit [7:0] DST_ID = 8'h00
) (
  input  logic          aclk,
  input  logic          arstn,
  input  logic [7:0]    in_s_tdata,
  input  logic          in_s_tvalid,
  output logic          in_s_tready,
  input  logic [7:0]    weight_s_tdata,
  input  logic          weight_s_tvalid,
  output logic          weight_s_tready,
  input  logic [7:0]    bias_s_tdata,
  input  logic          bias_s_tvalid,
  output logic          bias_s_tready,
  output logic [PW-1:0] lii_out_p0_tdata,
  output logic          lii_out_p0_tvalid,
  input  logic          lii_out_p0_tready,
  output logic [7:0]    lii_out_p0_src,
  output logic [7:0]    lii_out_p0_dst,
  output logic [31:0]   beat_count
);

  logic [7:0] in_byte;
  logic [7:0] weight_byte;
  logic [7:0] bias_byte;
  logic       in_avail;
  logic       weight_avail;
  logic       bias_avail;
  logic       out_free;
  logic       join_fire;
  logic       beat_taken;

  assign lii_out_p0_src = SRC_ID;
  assign lii_out_p0_dst = DST_ID;

  // The output slot is free when empty or being drained this cycle; a join
  // needs a byte on every lane plus a free slot, and pops all three lanes.
  assign out_free   = !lii_out_p0_tvalid | lii_out_p0_tready;
  assign join_fire  = in_avail & weight_avail & bias_avail & out_free;
  assign beat_taken = lii_out_p0_tvalid & lii_out_p0_tready;

  fc2_lii_lane_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .aclk       (aclk),
    .arstn      (arstn),
    .push_data  (in_s_tdata),
    .push_valid (in_s_tvalid),
    .push_ready (in_s_tready),
    .pop        (join_fire),
    .pop_data   (in_byte),
    .not_empty  (in_avail)
  );

  fc2_lii_lane_fifo #(.DEPTH(DEPTH)) u_weight_fifo (
    .aclk       (aclk),
    .arstn      (arstn),
    .push_data  (weight_s_tdata),
    .push_valid (weight_s_tvalid),
    .push_ready (weight_s_tready),
    .pop        (join_fire),
    .pop_data   (weight_byte),
    .not_empty  (weight_avail)
  );

  fc2_lii_lane_fifo #(.DEPTH(DEPTH)) u_bias_fifo (
    .aclk       (aclk),
    .arstn      (arstn),
    .push_data  (bias_s_tdata),
    .push_valid (bias_s_tvalid),
    .push_ready (bias_s_tready),
    .pop        (join_fire),
    .pop_data   (bias_byte),
    .not_empty  (bias_avail)
  );

  // Output beat register: load on join, clear valid when drained with no
  // replacement, otherwise hold (covers the stalled tvalid & !tready case).
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      lii_out_p0_tdata  <= '0;
      lii_out_p0_tvalid <= 1'b0;
    end else if (join_fire) begin
      lii_out_p0_tdata  <= {{(PW-24){1'b0}}, bias_byte, weight_byte, in_byte};
      lii_out_p0_tvalid <= 1'b1;
    end else if (lii_out_p0_tready) begin
      lii_out_p0_tvalid <= 1'b0;
    end
  end

  // Count every beat accepted downstream; wraps at 2^32.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      beat_count <= '0;
    end else if (beat_taken) begin
      beat_count <= beat_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fc2_lii_packer.sv
// Directed bench for fc2_lii_packer: reset, latency, lane skew, backpressure,
// reset mid-operation, full-with-pop, and a long random stream scoreboard.
module tb_fc2_lii_packer;

  localparam int PW = 64;

  logic          aclk = 1'b0;
  logic          arstn;
  logic [7:0]    in_d, w_d, b_d;
  logic          in_v, w_v, b_v;
  logic          in_r, w_r, b_r;
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [7:0]    src, dst;
  logic [31:0]   beat_count;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  fc2_lii_packer #(
    .PW(PW), .DEPTH(4), .SRC_ID(8'h5A), .DST_ID(8'hC3)
  ) dut (
    .aclk              (aclk),
    .arstn             (arstn),
    .in_s_tdata        (in_d),
    .in_s_tvalid       (in_v),
    .in_s_tready       (in_r),
    .weight_s_tdata    (w_d),
    .weight_s_tvalid   (w_v),
    .weight_s_tready   (w_r),
    .bias_s_tdata      (b_d),
    .bias_s_tvalid     (b_v),
    .bias_s_tready     (b_r),
    .lii_out_p0_tdata  (tdata),
    .lii_out_p0_tvalid (tvalid),
    .lii_out_p0_tready (tready),
    .lii_out_p0_src    (src),
    .lii_out_p0_dst    (dst),
    .beat_count        (beat_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id,
                       input logic wv, input logic [7:0] wd,
                       input logic bv, input logic [7:0] bd);
    in_v = iv; in_d = id;
    w_v  = wv; w_d  = wd;
    b_v  = bv; b_d  = bd;
  endtask

  function automatic logic [63:0] beat(input logic [7:0] a, input logic [7:0] w,
                                       input logic [7:0] b);
    return {40'h0, b, w, a};
  endfunction

  initial begin
    int n;
    int s;
    int seen;
    int stable_bad;
    int first_cyc;
    int last_cyc;
    logic [63:0] first_beat;
    logic [7:0] q_in[$];
    logic [7:0] q_w[$];
    logic [7:0] q_b[$];
    int sent_in, sent_w, sent_b, rx, cyc;

    // ---------------- reset state ----------------
    arstn = 1'b0;
    tready = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    #12;
    check("rst_tvalid", 64'(tvalid), 64'h0);
    check("rst_tdata", tdata, 64'h0);
    check("rst_beat_count", 64'(beat_count), 64'h0);
    check("rst_readies", 64'({in_r, w_r, b_r}), 64'h7);
    check("src_dst", 64'({src, dst}), 64'h5AC3);
    arstn = 1'b1;
    step();

    // ---------------- latency ----------------
    tready = 1'b1;
    drive(1, 8'h11, 1, 8'h22, 1, 8'h33);
    step();                                   // edge k: push
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    check("lat_no_valid_yet", 64'(tvalid), 64'h0);
    step();                                   // edge k+1: join
    check("lat_tvalid", 64'(tvalid), 64'h1);
    check("lat_tdata", tdata, 64'h0000_0000_0033_2211);
    check("lat_count_before", 64'(beat_count), 64'h0);
    step();                                   // edge k+2: accepted
    check("lat_count_after", 64'(beat_count), 64'h1);
    check("lat_tvalid_clear", 64'(tvalid), 64'h0);

    // ---------------- lane skew ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(i + 1), 0, 8'h00, 0, 8'h00);
      step();
    end
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    check("skew_in_full", 64'(in_r), 64'h0);
    check("skew_no_output", 64'(tvalid), 64'h0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(0, 8'h00, 1, 8'(8'hA0 + c), 1, 8'(8'hB0 + c));
      else       drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
      step();
      if (tvalid) begin
        check($sformatf("skew_beat%0d", n), tdata,
              beat(8'(n + 1), 8'(8'hA0 + n), 8'(8'hB0 + n)));
        n++;
      end
    end
    check("skew_beats", 64'(n), 64'd4);
    check("skew_in_ready_back", 64'(in_r), 64'h1);

    // ---------------- backpressure ----------------
    tready = 1'b0;
    s = 0; seen = 0; stable_bad = 0; first_beat = '0;
    for (int c = 0; c < 10; c++) begin
      drive(1, 8'(8'h40 + s), 1, 8'(8'h50 + s), 1, 8'(8'h60 + s));
      if (in_r && w_r && b_r) begin
        step();
        s++;
      end else begin
        step();
      end
      if (tvalid) begin
        if (seen == 0) begin
          first_beat = tdata;
          seen = 1;
        end else if (tdata !== first_beat) begin
          stable_bad++;
        end
      end
    end
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    check("bp_pushes", 64'(s), 64'd5);
    check("bp_readies_low", 64'({in_r, w_r, b_r}), 64'h0);
    check("bp_tvalid_held", 64'(tvalid), 64'h1);
    check("bp_first_beat", first_beat, 64'h0000_0000_0060_5040);
    check("bp_stable", 64'(stable_bad), 64'd0);
    tready = 1'b1;
    n = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      if (tvalid) begin
        check($sformatf("bp_beat%0d", n), tdata,
              beat(8'(8'h40 + n), 8'(8'h50 + n), 8'(8'h60 + n)));
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        n++;
      end
      step();
    end
    check("bp_release_beats", 64'(n), 64'd5);
    check("bp_back_to_back", 64'(last_cyc - first_cyc), 64'd4);
    check("bp_beat_count", 64'(beat_count), 64'd10);

    // ---------------- reset mid-operation ----------------
    tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1, 8'(8'h70 + c), 1, 8'(8'h74 + c), 1, 8'(8'h78 + c));
      step();
    end
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    check("mid_pre_tvalid", 64'(tvalid), 64'h1);
    check("mid_pre_occupancy", 64'(dut.u_in_fifo.count), 64'd3);
    #2 arstn = 1'b0;
    #1;
    check("mid_tvalid_async_drop", 64'(tvalid), 64'h0);
    check("mid_readies", 64'({in_r, w_r, b_r}), 64'h7);
    check("mid_beat_count", 64'(beat_count), 64'h0);
    #2 arstn = 1'b1;
    tready = 1'b1;
    drive(1, 8'h81, 1, 8'h82, 1, 8'h83);
    step();
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    step();
    check("mid_fresh_beat", tdata, 64'h0000_0000_0083_8281);
    step();
    check("mid_no_stale", 64'(tvalid), 64'h0);
    check("mid_count_one", 64'(beat_count), 64'h1);

    // ---------------- full with simultaneous pop ----------------
    tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1, 8'(8'h90 + c), 1, 8'(8'hA0 + c), 1, 8'(8'hB0 + c));
      step();
    end
    check("fwp_full", 64'(dut.u_in_fifo.count), 64'd4);
    drive(1, 8'h99, 0, 8'h00, 0, 8'h00);
    tready = 1'b1;
    check("fwp_ready_low", 64'(in_r), 64'h0);
    step();                                   // drain + join pop, no push
    check("fwp_occ_3", 64'(dut.u_in_fifo.count), 64'd3);
    check("fwp_ready_back", 64'(in_r), 64'h1);
    tready = 1'b0;
    step();                                   // push taken, no pop
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    check("fwp_occ_4", 64'(dut.u_in_fifo.count), 64'd4);
    check("fwp_weight_occ", 64'(dut.u_weight_fifo.count), 64'd3);

    // ---------------- random streaming ----------------
    arstn = 1'b0;
    #3 arstn = 1'b1;
    step();
    sent_in = 0; sent_w = 0; sent_b = 0; rx = 0; cyc = 0;
    while (rx < 1000 && cyc < 20000) begin
      in_v = (sent_in < 1000) && ($urandom_range(0, 3) != 0);
      w_v  = (sent_w < 1000) && ($urandom_range(0, 3) != 0);
      b_v  = (sent_b < 1000) && ($urandom_range(0, 3) != 0);
      in_d = 8'($urandom);
      w_d  = 8'($urandom);
      b_d  = 8'($urandom);
      tready = ($urandom_range(0, 3) != 0);
      if (tvalid && tready) begin
        if (q_in.size() == 0 || q_w.size() == 0 || q_b.size() == 0) begin
          check("rand_underflow", 64'(rx), 64'hFFFF_FFFF);
        end else begin
          check($sformatf("rand_beat%0d", rx), tdata,
                beat(q_in.pop_front(), q_w.pop_front(), q_b.pop_front()));
        end
        rx++;
      end
      if (in_v && in_r) begin q_in.push_back(in_d); sent_in++; end
      if (w_v && w_r)   begin q_w.push_back(w_d);   sent_w++;  end
      if (b_v && b_r)   begin q_b.push_back(b_d);   sent_b++;  end
      step();
      cyc++;
    end
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00);
    check("rand_beats_seen", 64'(rx), 64'd1000);
    check("rand_beat_count", 64'(beat_count), 64'd1000);
    check("rand_queues_drained", 64'(q_in.size() + q_w.size() + q_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
